// File: rtl/spm_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spm_seq_ctrl_pkg
// Description : Shared definitions for the scratchpad sequencer control slice.
//               Holds the FSM state encoding, the bit layout of one bank-group
//               field inside a context word, and a pointer-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package spm_seq_ctrl_pkg;

  // Per-bank-group field layout: {fifo_sel[1:0], en, sel, mode}
  localparam int FLD_MODE = 0;
  localparam int FLD_SEL  = 1;
  localparam int FLD_EN   = 2;
  localparam int FLD_FIFO = 3;
  localparam int FLD_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index width for a store of the given depth (never below one bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spm_seq_ctrl_cfg_store.sv
`default_nettype none
// ============================================================================
// Module      : spm_seq_ctrl_cfg_store
// Description : DEPTH x INST_W context store. Appends words while idle and not
//               full; a clear rewinds the write pointer. Asynchronous read.
// Ports       : clk, rst_n        clock, async active-low reset
//               i_idle            sequencer is idle (load/clear allowed)
//               i_valid/i_data    incoming context word
//               i_clear           empty the store
//               o_ready           store accepts a word this cycle
//               o_len             number of valid entries
//               i_raddr/o_rdata   asynchronous read port
// Revision    : 1.0 - initial release
// ============================================================================
module spm_seq_ctrl_cfg_store
  import spm_seq_ctrl_pkg::*;
#(
  parameter  int DEPTH  = 32,
  parameter  int INST_W = 24,
  localparam int PTR_W  = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_idle,
  input  logic              i_valid,
  input  logic [INST_W-1:0] i_data,
  input  logic              i_clear,
  output logic              o_ready,
  output logic [PTR_W:0]    o_len,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [INST_W-1:0] o_rdata
);

  logic [INST_W-1:0] r_mem [DEPTH];
  logic [PTR_W:0]    r_wr_ptr;
  logic              w_full;
  logic              w_wr;

  assign w_full  = (r_wr_ptr >= (PTR_W+1)'(DEPTH));
  assign o_ready = i_idle && !w_full;
  // A clear in the same cycle suppresses the write so nothing lands past len.
  assign w_wr    = i_valid && o_ready && !i_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
    end else if (i_idle && i_clear) begin
      r_wr_ptr <= '0;
    end else if (w_wr) begin
      r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
    end
  end

  // Contents are deliberately not reset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end
  end

  assign o_len   = r_wr_ptr;
  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/spm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spm_seq_ctrl
// Description : Scratchpad control front-end. Loads a context program, replays
//               it with per-entry repeat and a whole-program loop count, and
//               steers the external or per-group switch port into each bank
//               group according to the active context word.
// Ports       : clk, rst_n                     clock, async active-low reset
//               i_cfg_valid/i_cfg_data/o_cfg_ready  context load handshake
//               i_cfg_clear                    empty the store (idle only)
//               i_start/i_loop_cnt/i_stop      replay control
//               o_busy/o_done/o_ctx_idx        replay status
//               i_ex_*                         external port (all groups)
//               i_sw_*                         per-group switch ports
//               o_bg_*                         per-group bank-group ports
// Revision    : 1.0 - initial release
// ============================================================================
module spm_seq_ctrl
  import spm_seq_ctrl_pkg::*;
#(
  parameter  int N_BG   = 4,
  parameter  int A_W    = 10,
  parameter  int D_W    = 32,
  parameter  int DEPTH  = 32,
  parameter  int REP_W  = 4,
  parameter  int LOOP_W = 8,
  localparam int INST_W = REP_W + FLD_W*N_BG,
  localparam int PTR_W  = ptr_w(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_cfg_valid,
  input  logic [INST_W-1:0]   i_cfg_data,
  output logic                o_cfg_ready,
  input  logic                i_cfg_clear,
  input  logic                i_start,
  input  logic [LOOP_W-1:0]   i_loop_cnt,
  input  logic                i_stop,
  output logic                o_busy,
  output logic                o_done,
  output logic [PTR_W-1:0]    o_ctx_idx,
  input  logic                i_ex_wen,
  input  logic                i_ex_ren,
  input  logic [A_W-1:0]      i_ex_addr,
  input  logic [D_W-1:0]      i_ex_data,
  input  logic [N_BG-1:0]     i_sw_wen,
  input  logic [N_BG-1:0]     i_sw_ren,
  input  logic [N_BG*A_W-1:0] i_sw_addr,
  input  logic [N_BG*D_W-1:0] i_sw_data,
  output logic [N_BG-1:0]     o_bg_en,
  output logic [N_BG-1:0]     o_bg_mode,
  output logic [N_BG-1:0]     o_bg_wen,
  output logic [N_BG-1:0]     o_bg_ren,
  output logic [2*N_BG-1:0]   o_bg_fifo_sel,
  output logic [N_BG*A_W-1:0] o_bg_addr,
  output logic [N_BG*D_W-1:0] o_bg_data
);

  state_t              r_state;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [REP_W-1:0]    r_rep_cnt;
  logic [LOOP_W-1:0]   r_loops_left;
  logic [INST_W-1:0]   r_inst;

  logic                w_idle;
  logic [PTR_W:0]      w_len;
  logic                w_last;
  logic [PTR_W-1:0]    w_raddr;
  logic [INST_W-1:0]   w_rdata;
  logic [REP_W-1:0]    w_rdata_rep;

  assign w_idle = (r_state == ST_IDLE);

  spm_seq_ctrl_cfg_store #(
    .DEPTH  (DEPTH),
    .INST_W (INST_W)
  ) u_cfg_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_idle  (w_idle),
    .i_valid (i_cfg_valid),
    .i_data  (i_cfg_data),
    .i_clear (i_cfg_clear),
    .o_ready (o_cfg_ready),
    .o_len   (w_len),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Last entry when rd_ptr+1 reaches len (widened to avoid wrap at DEPTH).
  assign w_last      = (({1'b0, r_rd_ptr} + (PTR_W+1)'(1)) >= w_len);
  // Read port always presents the entry that would be loaded next:
  // entry 0 on start or wrap, rd_ptr+1 on a normal advance.
  assign w_raddr     = ((r_state == ST_RUN) && !w_last) ? (r_rd_ptr + PTR_W'(1)) : '0;
  assign w_rdata_rep = w_rdata[INST_W-1 -: REP_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rd_ptr     <= '0;
      r_rep_cnt    <= '0;
      r_loops_left <= '0;
      r_inst       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && (w_len != '0)) begin
            r_state      <= ST_RUN;
            r_inst       <= w_rdata;
            r_rd_ptr     <= '0;
            r_rep_cnt    <= w_rdata_rep;
            r_loops_left <= i_loop_cnt;
          end
        end
        ST_RUN: begin
          if (i_stop) begin
            r_state <= ST_IDLE;
            r_inst  <= '0;
          end else if (r_rep_cnt != '0) begin
            r_rep_cnt <= r_rep_cnt - REP_W'(1);
          end else if (!w_last) begin
            r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
            r_inst    <= w_rdata;
            r_rep_cnt <= w_rdata_rep;
          end else if (r_loops_left == '1) begin
            // All-ones loop count: replay until stopped.
            r_rd_ptr  <= '0;
            r_inst    <= w_rdata;
            r_rep_cnt <= w_rdata_rep;
          end else if (r_loops_left != '0) begin
            r_loops_left <= r_loops_left - LOOP_W'(1);
            r_rd_ptr     <= '0;
            r_inst       <= w_rdata;
            r_rep_cnt    <= w_rdata_rep;
          end else begin
            r_state <= ST_DONE;
            r_inst  <= '0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_inst  <= '0;
        end
      endcase
    end
  end

  assign o_busy    = (r_state == ST_RUN);
  assign o_done    = (r_state == ST_DONE);
  assign o_ctx_idx = r_rd_ptr;

  // Per-group steering. inst_r is zero outside RUN, so every group is
  // disabled and its accesses gated off there.
  for (genvar g = 0; g < N_BG; g++) begin : g_bg
    logic [FLD_W-1:0] w_fld;
    logic             w_sel;
    logic             w_en;

    assign w_fld = r_inst[FLD_W*g +: FLD_W];
    assign w_sel = w_fld[FLD_SEL];
    assign w_en  = w_fld[FLD_EN];

    assign o_bg_en[g]              = w_en;
    assign o_bg_mode[g]            = w_fld[FLD_MODE];
    assign o_bg_fifo_sel[2*g +: 2] = w_fld[FLD_FIFO +: 2];
    assign o_bg_wen[g]  = (w_sel ? i_sw_wen[g] : i_ex_wen) & w_en;
    assign o_bg_ren[g]  = (w_sel ? i_sw_ren[g] : i_ex_ren) & w_en;
    assign o_bg_addr[A_W*g +: A_W] = w_sel ? i_sw_addr[A_W*g +: A_W] : i_ex_addr;
    assign o_bg_data[D_W*g +: D_W] = w_sel ? i_sw_data[D_W*g +: D_W] : i_ex_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_spm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spm_seq_ctrl
// Description : Self-checking bench for spm_seq_ctrl: reset, basic replay,
//               repeat/loop, full store, abort, and a table of gating vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spm_seq_ctrl;

  localparam int N_BG   = 4;
  localparam int A_W    = 10;
  localparam int D_W    = 32;
  localparam int DEPTH  = 32;
  localparam int REP_W  = 4;
  localparam int LOOP_W = 8;
  localparam int INST_W = REP_W + 5*N_BG;
  localparam int PTR_W  = 5;

  logic                clk;
  logic                rst_n;
  logic                cfg_valid;
  logic [INST_W-1:0]   cfg_data;
  logic                cfg_ready;
  logic                cfg_clear;
  logic                start;
  logic [LOOP_W-1:0]   loop_cnt;
  logic                stop;
  logic                busy;
  logic                done;
  logic [PTR_W-1:0]    ctx_idx;
  logic                ex_wen, ex_ren;
  logic [A_W-1:0]      ex_addr;
  logic [D_W-1:0]      ex_data;
  logic [N_BG-1:0]     sw_wen, sw_ren;
  logic [N_BG*A_W-1:0] sw_addr;
  logic [N_BG*D_W-1:0] sw_data;
  logic [N_BG-1:0]     bg_en, bg_mode, bg_wen, bg_ren;
  logic [2*N_BG-1:0]   bg_fifo_sel;
  logic [N_BG*A_W-1:0] bg_addr;
  logic [N_BG*D_W-1:0] bg_data;

  int n_checks = 0;
  int n_errors = 0;

  spm_seq_ctrl #(
    .N_BG(N_BG), .A_W(A_W), .D_W(D_W), .DEPTH(DEPTH), .REP_W(REP_W), .LOOP_W(LOOP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cfg_valid(cfg_valid), .i_cfg_data(cfg_data), .o_cfg_ready(cfg_ready),
    .i_cfg_clear(cfg_clear), .i_start(start), .i_loop_cnt(loop_cnt), .i_stop(stop),
    .o_busy(busy), .o_done(done), .o_ctx_idx(ctx_idx),
    .i_ex_wen(ex_wen), .i_ex_ren(ex_ren), .i_ex_addr(ex_addr), .i_ex_data(ex_data),
    .i_sw_wen(sw_wen), .i_sw_ren(sw_ren), .i_sw_addr(sw_addr), .i_sw_data(sw_data),
    .o_bg_en(bg_en), .o_bg_mode(bg_mode), .o_bg_wen(bg_wen), .o_bg_ren(bg_ren),
    .o_bg_fifo_sel(bg_fifo_sel), .o_bg_addr(bg_addr), .o_bg_data(bg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       ex_wen;
    logic       ex_ren;
    logic [3:0] sw_wen;
    logic [3:0] sw_ren;
    logic [3:0] exp_wen;
    logic [3:0] exp_ren;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [INST_W-1:0] d);
    cfg_valid = 1'b1;
    cfg_data  = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic clear_store();
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
  endtask

  task automatic start_prog(input logic [LOOP_W-1:0] l);
    start    = 1'b1;
    loop_cnt = l;
    tick();
    start    = 1'b0;
  endtask

  // Rebuild the visible fields (sel is not an output, so it reads as 0).
  function automatic logic [19:0] vis_fields(input logic [3:0] en, input logic [3:0] mode,
                                             input logic [7:0] fifo);
    logic [19:0] f;
    f = '0;
    for (int g = 0; g < 4; g++) begin
      f[5*g +: 5] = {fifo[2*g +: 2], en[g], 1'b0, mode[g]};
    end
    return f;
  endfunction

  initial begin
    // Gating program: BG0 en/ex, BG1 en/sw, BG2 dis/sw, BG3 dis/ex.
    vecs[0] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    vecs[1] = '{1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    vecs[2] = '{1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0010, 4'b0000};
    vecs[3] = '{1'b0, 1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0011};
    vecs[4] = '{1'b1, 1'b0, 4'b1111, 4'b0100, 4'b0011, 4'b0000};
    vecs[5] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0; cfg_clear = 1'b0;
    start = 1'b0; loop_cnt = '0; stop = 1'b0;
    ex_wen = 1'b0; ex_ren = 1'b0; ex_addr = 10'h155; ex_data = 32'hE0E0_E0E0;
    sw_wen = '0; sw_ren = '0;
    sw_addr = {10'h3A3, 10'h2B2, 10'h1C1, 10'h0D0};
    sw_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_AAAA};
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ---------------- reset values
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ctx_idx", ctx_idx, 0);
    chk("rst_bg_en", bg_en, 0);

    // ---------------- reset mid-load / mid-run
    load_word(24'h0FFFFF);
    load_word(24'h0FFFFF);
    load_word(24'h0FFFFF);
    start_prog(8'hFF);
    tick();
    chk("prerst_bg_en", bg_en, 4'hF);
    rst_n = 1'b0;
    #1;
    chk("midrst_cfg_ready", cfg_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_bg_en", bg_en, 0);
    chk("midrst_bg_wen_ren", {bg_wen, bg_ren, bg_mode, bg_fifo_sel}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    start_prog(8'h00);
    chk("len0_start_ignored", busy, 0);

    // ---------------- basic two-entry replay
    sw_wen = 4'b0001; ex_ren = 1'b1;
    load_word(24'h000006);
    load_word(24'h000080);
    start_prog(8'h00);
    chk("basic_c1_busy", busy, 1);
    chk("basic_c1_en", bg_en, 4'b0001);
    chk("basic_c1_wen", bg_wen, 4'b0001);
    chk("basic_c1_ren", bg_ren, 4'b0000);
    chk("basic_c1_addr0", bg_addr[9:0], 10'h0D0);
    chk("basic_c1_data0", bg_data[31:0], 32'h0000_AAAA);
    chk("basic_c1_ctx", ctx_idx, 0);
    tick();
    chk("basic_c2_busy", busy, 1);
    chk("basic_c2_en", bg_en, 4'b0010);
    chk("basic_c2_wen", bg_wen, 4'b0000);
    chk("basic_c2_ren", bg_ren, 4'b0010);
    chk("basic_c2_addr1", bg_addr[19:10], 10'h155);
    chk("basic_c2_ctx", ctx_idx, 1);
    tick();
    chk("basic_c3_done", done, 1);
    chk("basic_c3_busy", busy, 0);
    chk("basic_c3_en", bg_en, 0);
    tick();
    chk("basic_c4_done", done, 0);
    sw_wen = '0; ex_ren = 1'b0;

    // ---------------- repeat / loop
    begin
      int exp_ctx [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
      clear_store();
      load_word(24'h200004);
      load_word(24'h000080);
      start_prog(8'h01);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("rep_busy_%0d", i), busy, 1);
        chk($sformatf("rep_done_%0d", i), done, 0);
        chk($sformatf("rep_ctx_%0d", i), ctx_idx, exp_ctx[i]);
        tick();
      end
      chk("rep_done_pulse", done, 1);
      chk("rep_end_busy", busy, 0);
      tick();
      chk("rep_done_once", done, 0);
    end

    // ---------------- full store
    clear_store();
    cfg_valid = 1'b1;
    for (int k = 0; k < DEPTH + 2; k++) begin
      cfg_data = {4'h0, 20'hA5A00 + 20'(k)};
      chk($sformatf("full_ready_%0d", k), cfg_ready, (k < DEPTH) ? 1 : 0);
      tick();
    end
    cfg_valid = 1'b0;
    start_prog(8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("full_ctx_%0d", i), ctx_idx, i);
      chk($sformatf("full_word_%0d", i), vis_fields(bg_en, bg_mode, bg_fifo_sel),
          (20'hA5A00 + 20'(i)) & 20'hEF7BD);
      tick();
    end
    chk("full_done", done, 1);
    tick();

    // ---------------- abort an infinite loop
    clear_store();
    load_word(24'h000006);
    load_word(24'h000080);
    start_prog(8'hFF);
    for (int i = 0; i < 19; i++) begin
      chk($sformatf("abort_busy_%0d", i), busy, 1);
      chk($sformatf("abort_ctx_%0d", i), ctx_idx, i % 2);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bg_en", bg_en, 0);
    chk("abort_cfg_ready", cfg_ready, 1);
    tick();
    chk("abort_no_done", done, 0);

    // ---------------- gating table
    clear_store();
    load_word(24'h0008C4);
    start_prog(8'hFF);
    chk("gate_bg_en", bg_en, 4'b0011);
    for (int v = 0; v < 6; v++) begin
      ex_wen = vecs[v].ex_wen;
      ex_ren = vecs[v].ex_ren;
      sw_wen = vecs[v].sw_wen;
      sw_ren = vecs[v].sw_ren;
      #1;
      chk($sformatf("gate_wen_%0d", v), bg_wen, vecs[v].exp_wen);
      chk($sformatf("gate_ren_%0d", v), bg_ren, vecs[v].exp_ren);
      chk($sformatf("gate_addr_%0d", v), bg_addr, {10'h155, 10'h2B2, 10'h1C1, 10'h155});
      tick();
    end
    chk("gate_data", bg_data,
        {32'hE0E0_E0E0, 32'h2222_2222, 32'h1111_1111, 32'hE0E0_E0E0});
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("gate_stopped", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
